// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial adder. Latches two WIDTH-bit operands and a carry-in
//            on an accepted start, then adds one bit per clock (LSB first)
//            through a single full-adder cell and a carry flip-flop.
//            Presents the registered sum and carry-out with a one-cycle
//            done pulse.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            start_i    - request, sampled only when not busy
//            a_i, b_i   - operands, latched on accepted start
//            ci_i       - carry-in, latched on accepted start
//            busy_o     - high while bits are being processed
//            done_o     - one-cycle pulse, s_o/co_o valid from this cycle on
//            s_o, co_o  - registered sum / carry-out, held between results
//            ovf_o      - signed overflow (only with SERIAL_ADDER_OVF_EN)
// Macros   : SERIAL_ADDER_OVF_EN - adds the ovf_o port and its logic
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             co_o
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  // One extra counter bit so the count never wraps before the terminal compare.
  localparam int             CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   s_sh_q, s_sh_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               co_q, co_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  // Full-adder cell operating on the current LSBs and the carry flip-flop.
  logic               sum_bit;
  logic               carry_out;
  logic [WIDTH-1:0]   s_shift;

  assign sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign carry_out = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) |
                     (b_sh_q[0] & carry_q);

  // Sum bits enter from the MSB end so that after WIDTH shifts bit 0 of the
  // result sits at bit 0 of the register.
  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign s_shift = sum_bit;
    end else begin : g_shift_wn
      assign s_shift = {sum_bit, s_sh_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    s_d     = s_q;
    co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          carry_d = ci_i;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = s_shift;
        carry_d = carry_out;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Final bit: publish the complete sum including this bit.
          s_d     = s_shift;
          co_d    = carry_out;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB at this point.
          ovf_d   = carry_q ^ carry_out;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);
  assign s_o    = s_q;
  assign co_o   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Directed self-checking bench for serial_adder. Drives a WIDTH=8
//            instance and a WIDTH=1 instance from a shared clock and reset.
// Macros   : SERIAL_ADDER_OVF_EN - also checks the ovf output
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // WIDTH = 8 instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ci8 = 1'b0;
  logic       busy8, done8, co8;
  logic [7:0] s8;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8;
`endif

  // WIDTH = 1 instance
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ci1 = 1'b0;
  logic       busy1, done1, co1;
  logic [0:0] s1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf1;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .a_i(a8), .b_i(b8),
    .ci_i(ci8), .busy_o(busy8), .done_o(done8), .s_o(s8), .co_o(co8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf_o(ovf8)
`endif
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .a_i(a1), .b_i(b1),
    .ci_i(ci1), .busy_o(busy1), .done_o(done1), .s_o(s1), .co_o(co1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf_o(ovf1)
`endif
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start for exactly one edge; returns just after the accepting edge.
  task automatic start_w8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    a8 = a; b8 = b; ci8 = ci; start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  // Tick until done8 is seen, bounded; n = edges taken.
  task automatic wait_done8(output int n);
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done1(output int n);
    n = 0;
    while (done1 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({busy8, done8, s8, co8} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_w8: busy=%b done=%b s=%h co=%b, expected all 0", busy8, done8, s8, co8);
    end
    tests_run++;
    if ({busy1, done1, s1, co1} !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_w1: busy=%b done=%b s=%b co=%b, expected all 0", busy1, done1, s1, co1);
    end
`ifdef SERIAL_ADDER_OVF_EN
    tests_run++;
    if (ovf8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ovf: got %b, expected 0", ovf8);
    end
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero();
    int nbusy;
    start_w8(8'h00, 8'h00, 1'b0);
    nbusy = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy8 === 1'b1 && done8 === 1'b0) nbusy++;
      tick();
    end
    tests_run++;
    if (nbusy != 8) begin
      tests_failed++;
      $display("FAIL zero_busy_cycles: got %0d, expected 8", nbusy);
    end
    tests_run++;
    if ({done8, busy8, s8, co8} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL zero_result: done=%b busy=%b s=%h co=%b, expected done=1 busy=0 s=00 co=0",
               done8, busy8, s8, co8);
    end
    tick();
    tests_run++;
    if (done8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_done_pulse: done=%b one cycle later, expected 0", done8);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    start_w8(8'hFF, 8'h01, 1'b0);
    wait_done8(n);
    tests_run++;
    if (n != 8 || s8 !== 8'h00 || co8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL carry_ff01: n=%0d s=%h co=%b, expected n=8 s=00 co=1", n, s8, co8);
    end
    // Issue the next operation during the DONE cycle.
    a8 = 8'hA5; b8 = 8'h5A; ci8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tests_run++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_accept: busy=%b done=%b, expected busy=1 done=0", busy8, done8);
    end
    wait_done8(n);
    tests_run++;
    if (n != 8 || s8 !== 8'h00 || co8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_result: n=%0d s=%h co=%b, expected n=8 s=00 co=1", n, s8, co8);
    end
    tick();
  endtask

  task automatic test_ovf();
    int n;
    start_w8(8'h7F, 8'h01, 1'b0);
    wait_done8(n);
    tests_run++;
    if (n != 8 || s8 !== 8'h80 || co8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_7f01: n=%0d s=%h co=%b, expected n=8 s=80 co=0", n, s8, co8);
    end
`ifdef SERIAL_ADDER_OVF_EN
    tests_run++;
    if (ovf8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_7f01_flag: got %b, expected 1", ovf8);
    end
`endif
    tick();
    start_w8(8'h80, 8'h80, 1'b0);
    wait_done8(n);
    tests_run++;
    if (n != 8 || s8 !== 8'h00 || co8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_8080: n=%0d s=%h co=%b, expected n=8 s=00 co=1", n, s8, co8);
    end
`ifdef SERIAL_ADDER_OVF_EN
    tests_run++;
    if (ovf8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_8080_flag: got %b, expected 1", ovf8);
    end
`endif
    tick();
  endtask

  task automatic test_ignore_start();
    int n;
    start_w8(8'h12, 8'h34, 1'b0);
    tick();
    tick();
    // Third RUN cycle: new start and changed operands must be ignored.
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8(n);
    tests_run++;
    if (n != 5 || s8 !== 8'h46 || co8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_start: n=%0d s=%h co=%b, expected n=5 s=46 co=0", n, s8, co8);
    end
`ifdef SERIAL_ADDER_OVF_EN
    tests_run++;
    if (ovf8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_start_ovf: got %b, expected 0", ovf8);
    end
`endif
    // Result holds while idle with changing operands.
    a8 = 8'h99; b8 = 8'h77;
    tick();
    tick();
    tick();
    tests_run++;
    if (s8 !== 8'h46 || co8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_result: s=%h co=%b busy=%b done=%b, expected s=46 co=0 busy=0 done=0",
               s8, co8, busy8, done8);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    int ndone;
    start_w8(8'hC3, 8'h4E, 1'b0);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: busy=%b done=%b s=%h co=%b, expected all 0", busy8, done8, s8, co8);
    end
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done8 === 1'b1) ndone++;
    end
    tests_run++;
    if (ndone != 0) begin
      tests_failed++;
      $display("FAIL reset_no_done: got %0d done cycles, expected 0", ndone);
    end
    rst_n = 1'b1;
    tick();
    start_w8(8'hC3, 8'h4E, 1'b0);
    wait_done8(n);
    tests_run++;
    if (n != 8 || s8 !== 8'h11 || co8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL after_reset: n=%0d s=%h co=%b, expected n=8 s=11 co=1", n, s8, co8);
    end
    tick();
  endtask

  task automatic test_width1();
    logic [1:0] exp_tab [8];
    logic [2:0] v;
    int n;
    exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      ci1 = v[2]; a1 = v[1]; b1 = v[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      wait_done1(n);
      tests_run++;
      if (n != 1 || {co1, s1} !== exp_tab[i]) begin
        tests_failed++;
        $display("FAIL w1_cab_%0d: n=%0d {co,s}=%b, expected n=1 {co,s}=%b", i, n, {co1, s1}, exp_tab[i]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_back_to_back();
    test_ovf();
    test_ignore_start();
    test_reset_mid_run();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
